ram_access_ctrl: RTL and testbench

Initiator-side controller that drives the dual-port data RAM's write and registered-read ports on behalf of the RISC-V core's load/store stage. It accepts one byte-addressed load or store request at a time and converts it into RAM word address, byte mask and lane-replicated write data. For loads it waits out the RAM's one-cycle registered read latency, then extracts, sign- or zero-extends and returns the result. Misaligned and illegal accesses are rejected without touching the RAM.

---
 rtl/ram_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// Load/store controller for the core's data RAM: maps byte requests onto the
// RAM write port and registered read port, with alignment and funct3 checks.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | RAM enable driven (write or read)
// WAIT  | read data arriving, extract and extend
// RESP  | response held until rsp_ready
module ram_access_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_store,
  input  logic [2:0]                req_funct3,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_error,
  output logic                      ram_wr_en,
  output logic [3:0]                ram_wr_mask,
  output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [31:0]               ram_wr_data,
  output logic                      ram_rd_en,
  output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [31:0]               ram_rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                    state_q, state_d;
  logic                      store_q;
  logic [2:0]                funct3_q;
  logic [RAM_ADDR_WIDTH-1:0] waddr_q;
  logic [1:0]                lane_q;
  logic [31:0]               wdata_q;
  logic [31:0]               rdata_q;
  logic                      error_q;

  logic        legal;
  logic        accept;
  logic        wr_act, rd_act;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Upper byte-address bits beyond the RAM are intentionally dropped (wrap).
  logic unused_addr;
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2];

  assign accept = (state_q == IDLE) && req_valid;

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~req_addr[0];
      3'b010:  legal = (req_addr[1:0] == 2'b00);
      3'b100:  legal = ~req_store;
      3'b101:  legal = ~req_store & ~req_addr[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = legal ? ISSUE : RESP;
      ISSUE:   state_d = store_q ? RESP : WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    wr_mask = 4'b1111;
    wr_data = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        wr_mask = 4'b0001 << lane_q;
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_mask = lane_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ram_rd_data[7:0];
    case (lane_q)
      2'd1:    ld_byte = ram_rd_data[15:8];
      2'd2:    ld_byte = ram_rd_data[23:16];
      2'd3:    ld_byte = ram_rd_data[31:24];
      default: ld_byte = ram_rd_data[7:0];
    endcase
    ld_half = lane_q[1] ? ram_rd_data[31:16] : ram_rd_data[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = ram_rd_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      waddr_q  <= '0;
      lane_q   <= 2'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      error_q  <= 1'b0;
    end else if (accept) begin
      store_q  <= req_store;
      funct3_q <= req_funct3;
      waddr_q  <= req_addr[RAM_ADDR_WIDTH+1:2];
      lane_q   <= req_addr[1:0];
      wdata_q  <= req_wdata;
      rdata_q  <= 32'd0;
      error_q  <= ~legal;
    end else if (state_q == WAIT) begin
      rdata_q  <= ld_data;
    end
  end

  assign wr_act = (state_q == ISSUE) && store_q;
  assign rd_act = (state_q == ISSUE) && !store_q;

  assign ram_wr_en   = wr_act;
  assign ram_wr_mask = wr_act ? wr_mask : 4'd0;
  assign ram_wr_addr = wr_act ? waddr_q : '0;
  assign ram_wr_data = wr_act ? wr_data : 32'd0;
  assign ram_rd_en   = rd_act;
  assign ram_rd_addr = rd_act ? waddr_q : '0;

  // Held low while reset is asserted, even though the state reads IDLE.
  assign req_ready = rst_n && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_error = rsp_valid && error_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural registered-read RAM.
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        ram_wr_en;
  logic [3:0]  ram_wr_mask;
  logic [9:0]  ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic        ram_rd_en;
  logic [9:0]  ram_rd_addr;
  logic [31:0] ram_rd_data;

  int nerr = 0;
  int nchk = 0;
  int collide = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] rd_q = 32'd0;

  always #5 clk = ~clk;

  ram_access_ctrl #(.ADDR_WIDTH(32), .RAM_ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .ram_wr_en(ram_wr_en), .ram_wr_mask(ram_wr_mask), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data)
  );

  always @(posedge clk) begin
    if (ram_wr_en)
      for (int b = 0; b < 4; b++)
        if (ram_wr_mask[b]) mem[ram_wr_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
    if (ram_rd_en) rd_q <= mem[ram_rd_addr];
  end
  assign ram_rd_data = rd_q;

  always @(negedge clk) if (ram_wr_en && ram_rd_en) collide++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  // Caller is at the negedge where rsp_valid was just checked.
  task automatic complete(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_idle_novalid"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] em,
                          input logic [9:0] ea, input logic [31:0] ed);
    drive(1'b1, f3, a, d);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 32'h5555_5555;
    chk({tag, "_wr_en"}, 32'(ram_wr_en), 32'd1);
    chk({tag, "_mask"}, 32'(ram_wr_mask), 32'(em));
    chk({tag, "_waddr"}, 32'(ram_wr_addr), 32'(ea));
    chk({tag, "_wdata"}, ram_wr_data, ed);
    chk({tag, "_busy"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_wr_once"}, 32'(ram_wr_en), 32'd0);
    chk({tag, "_rsp"}, {30'd0, rsp_valid, rsp_error}, 32'h2);
    chk({tag, "_rdata0"}, rsp_rdata, 32'd0);
    complete(tag);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [9:0] ea, input logic [31:0] ed);
    drive(1'b0, f3, a, 32'hFFFF_FFFF);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_rd_en"}, {30'd0, ram_rd_en, ram_wr_en}, 32'h2);
    chk({tag, "_raddr"}, 32'(ram_rd_addr), 32'(ea));
    @(negedge clk);
    chk({tag, "_wait"}, {30'd0, ram_rd_en, rsp_valid}, 32'd0);
    chk({tag, "_raddr0"}, 32'(ram_rd_addr), 32'd0);
    @(negedge clk);
    chk({tag, "_rsp"}, {30'd0, rsp_valid, rsp_error}, 32'h2);
    chk({tag, "_rdata"}, rsp_rdata, ed);
    complete(tag);
  endtask

  task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a);
    drive(st, f3, a, 32'hABCD_EF01);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_rsp"}, {30'd0, rsp_valid, rsp_error}, 32'h3);
    chk({tag, "_rdata0"}, rsp_rdata, 32'd0);
    chk({tag, "_noen"}, {30'd0, ram_wr_en, ram_rd_en}, 32'd0);
    complete(tag);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_outs", {28'd0, rsp_valid, rsp_error, ram_wr_en, ram_rd_en}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    do_store("sw10", 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 10'd4, 32'hDEAD_BEEF);
    do_load ("lw10", 3'b010, 32'h0000_0010, 10'd4, 32'hDEAD_BEEF);
    do_store("sb13", 3'b000, 32'h0000_0013, 32'h0000_00A5, 4'b1000, 10'd4, 32'hA5A5_A5A5);
    do_store("sh10", 3'b001, 32'h0000_0010, 32'h0000_1234, 4'b0011, 10'd4, 32'h1234_1234);
    do_load ("lw10b", 3'b010, 32'h0000_0010, 10'd4, 32'hA5AD_1234);
    do_store("sh26", 3'b001, 32'h0000_0026, 32'h0000_CAFE, 4'b1100, 10'd9, 32'hCAFE_CAFE);
    do_load ("lhu26", 3'b101, 32'h0000_0026, 10'd9, 32'h0000_CAFE);

    do_store("sw20", 3'b010, 32'h0000_0020, 32'h80FF_7F01, 4'b1111, 10'd8, 32'h80FF_7F01);
    do_load ("lb22",  3'b000, 32'h0000_0022, 10'd8, 32'hFFFF_FFFF);
    do_load ("lbu22", 3'b100, 32'h0000_0022, 10'd8, 32'h0000_00FF);
    do_load ("lh22",  3'b001, 32'h0000_0022, 10'd8, 32'hFFFF_80FF);
    do_load ("lhu20", 3'b101, 32'h0000_0020, 10'd8, 32'h0000_7F01);
    do_load ("lb21",  3'b000, 32'h0000_0021, 10'd8, 32'h0000_007F);
    do_load ("lbu23", 3'b100, 32'h0000_0023, 10'd8, 32'h0000_0080);

    do_err("lw_mis", 1'b0, 3'b010, 32'h0000_0002);
    do_err("sh_mis", 1'b1, 3'b001, 32'h0000_0001);
    do_err("st_f3_4", 1'b1, 3'b100, 32'h0000_0000);
    do_err("ld_f3_3", 1'b0, 3'b011, 32'h0000_0000);
    do_err("lhu_mis", 1'b0, 3'b101, 32'h0000_0023);

    do_store("sw0", 3'b010, 32'h0000_0000, 32'h1357_9BDF, 4'b1111, 10'd0, 32'h1357_9BDF);
    drive(1'b0, 3'b010, 32'h0000_1000, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wrap_rd_en", 32'(ram_rd_en), 32'd1);
    chk("wrap_raddr", 32'(ram_rd_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h0000_0004, 32'hFFFF_FFFF);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h1357_9BDF);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_nowr", 32'(ram_wr_en), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp_last", rsp_rdata, 32'h1357_9BDF);
    complete("bp");
    chk("bp_mem4_kept", mem[1], 32'd0);

    drive(1'b0, 3'b010, 32'h0000_0010, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rl_rd_en", 32'(ram_rd_en), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rl_ready", 32'(req_ready), 32'd0);
    chk("rl_outs", {28'd0, rsp_valid, rsp_error, ram_wr_en, ram_rd_en}, 32'd0);
    chk("rl_buses", {12'd0, ram_rd_addr, ram_wr_addr}, 32'd0);
    chk("rl_wdata", ram_wr_data, 32'd0);
    chk("rl_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rl_after_ready", 32'(req_ready), 32'd1);
      chk("rl_after_novalid", 32'(rsp_valid), 32'd0);
    end
    do_load("lw_after_rst", 3'b010, 32'h0000_0010, 10'd4, 32'hA5AD_1234);

    chk("no_collide", 32'(collide), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
